pio_sm_exec: RTL and testbench

Parametrised PIO state-machine execution core for the RP2040 PIO block: fetches 16-bit instructions from the shared instruction memory, executes JMP (all eight conditions) and SET, and handles delay, program wrap, forced execution and restart. One instance sits per state machine between the instruction memory, the fractional clock divider and the GPIO/pin-mapping logic. Compared with the previous core it has parametrised PC and scratch widths, a real SET path and a forced-instruction port.

---
 rtl/pio_sm_exec.sv | 174 +++++++++++++++++
 tb/tb_pio_sm_exec.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_sm_exec.sv
// PIO state-machine execution core: fetch, JMP/SET execute, delay, wrap, forced exec, restart.
// Define PIO_SET_INSTR_EN to enable the SET instruction; otherwise SET executes as a NOP.
module pio_sm_exec #(
  parameter int unsigned PC_W  = 5,
  parameter int unsigned XY_W  = 32,
  parameter int unsigned SET_N = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic             clk_en,
  input  logic [PC_W-1:0]  wrap_bottom,
  input  logic [PC_W-1:0]  wrap_top,
  input  logic [15:0]      instr_data,
  input  logic             exec_valid,
  input  logic [15:0]      exec_instr,
  input  logic             jmp_pin,
  input  logic             osr_empty,
  output logic [PC_W-1:0]  pc,
  output logic [XY_W-1:0]  x,
  output logic [XY_W-1:0]  y,
  output logic [SET_N-1:0] set_pins,
  output logic [SET_N-1:0] set_pindirs,
  output logic             pins_we,
  output logic             pindirs_we,
  output logic             stalled
);

  typedef enum logic [1:0] {StIdle, StExec, StDelay} state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [XY_W-1:0]  x_q, x_d, y_q, y_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [SET_N-1:0] set_pins_q, set_pins_d, set_pindirs_q, set_pindirs_d;
  logic             pins_we_q, pins_we_d, pindirs_we_q, pindirs_we_d;

  logic [15:0]      instr;
  logic [2:0]       opcode, cond;
  logic [4:0]       delay, data;
  logic             taken;
  logic             do_exec;
  logic [PC_W-1:0]  seq_pc;

  assign instr  = exec_valid ? exec_instr : instr_data;
  assign opcode = instr[15:13];
  assign delay  = instr[12:8];
  assign cond   = instr[7:5];
  assign data   = instr[4:0];
  assign seq_pc = (pc_q == wrap_top) ? wrap_bottom : pc_q + PC_W'(1);

  // X/Y zero tests use the pre-decrement value.
  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b000: taken = 1'b1;
      3'b001: taken = (x_q == '0);
      3'b010: taken = (x_q != '0);
      3'b011: taken = (y_q == '0);
      3'b100: taken = (y_q != '0);
      3'b101: taken = (x_q != y_q);
      3'b110: taken = jmp_pin;
      3'b111: taken = !osr_empty;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    x_d           = x_q;
    y_d           = y_q;
    cnt_d         = cnt_q;
    set_pins_d    = set_pins_q;
    set_pindirs_d = set_pindirs_q;
    pins_we_d     = 1'b0;
    pindirs_we_d  = 1'b0;
    do_exec       = 1'b0;

    if (restart) begin
      x_d     = '0;
      y_d     = '0;
      cnt_d   = '0;
      state_d = enable ? StExec : StIdle;
    end else if (!enable) begin
      state_d = StIdle;
    end else if (clk_en) begin
      unique case (state_q)
        StIdle:  state_d = StExec;
        StExec:  do_exec = 1'b1;
        StDelay: begin
          // A forced instruction cancels whatever delay remains.
          if (exec_valid) begin
            do_exec = 1'b1;
          end else if (cnt_q <= 5'd1) begin
            cnt_d   = '0;
            state_d = StExec;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (do_exec) begin
      pc_d = seq_pc;
      if (opcode == 3'b000) begin
        if (cond == 3'b010) x_d = x_q - XY_W'(1);
        if (cond == 3'b100) y_d = y_q - XY_W'(1);
        if (taken) pc_d = instr[PC_W-1:0];
      end
`ifdef PIO_SET_INSTR_EN
      else if (opcode == 3'b111) begin
        unique case (cond)
          3'b000: begin
            set_pins_d = data[SET_N-1:0];
            pins_we_d  = 1'b1;
          end
          3'b001: x_d = XY_W'(data);
          3'b010: y_d = XY_W'(data);
          3'b100: begin
            set_pindirs_d = data[SET_N-1:0];
            pindirs_we_d  = 1'b1;
          end
          default: ;
        endcase
      end
`endif
      if (delay != 5'd0) begin
        cnt_d   = delay;
        state_d = StDelay;
      end else begin
        cnt_d   = '0;
        state_d = StExec;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      set_pins_q    <= '0;
      set_pindirs_q <= '0;
      pins_we_q     <= 1'b0;
      pindirs_we_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cnt_q         <= cnt_d;
      set_pins_q    <= set_pins_d;
      set_pindirs_q <= set_pindirs_d;
      pins_we_q     <= pins_we_d;
      pindirs_we_q  <= pindirs_we_d;
    end
  end

  assign pc          = pc_q;
  assign x           = x_q;
  assign y           = y_q;
  assign set_pins    = set_pins_q;
  assign set_pindirs = set_pindirs_q;
  assign pins_we     = pins_we_q;
  assign pindirs_we  = pindirs_we_q;
  assign stalled     = (state_q == StDelay);

endmodule

// File: tb/tb_pio_sm_exec.sv
// Directed self-checking bench for pio_sm_exec; expectations follow PIO_SET_INSTR_EN.
module tb_pio_sm_exec;
  localparam int unsigned PC_W  = 5;
  localparam int unsigned XY_W  = 32;
  localparam int unsigned SET_N = 5;
`ifdef PIO_SET_INSTR_EN
  localparam bit SetEn = 1'b1;
`else
  localparam bit SetEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, enable, restart, clk_en;
  logic [PC_W-1:0]  wrap_bottom, wrap_top;
  logic [15:0]      instr_data, exec_instr;
  logic             exec_valid, jmp_pin, osr_empty;
  logic [PC_W-1:0]  pc;
  logic [XY_W-1:0]  x, y;
  logic [SET_N-1:0] set_pins, set_pindirs;
  logic             pins_we, pindirs_we, stalled;

  logic [15:0] mem [32];
  assign instr_data = mem[pc];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pio_sm_exec #(.PC_W(PC_W), .XY_W(XY_W), .SET_N(SET_N)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .restart    (restart),
    .clk_en     (clk_en),
    .wrap_bottom(wrap_bottom),
    .wrap_top   (wrap_top),
    .instr_data (instr_data),
    .exec_valid (exec_valid),
    .exec_instr (exec_instr),
    .jmp_pin    (jmp_pin),
    .osr_empty  (osr_empty),
    .pc         (pc),
    .x          (x),
    .y          (y),
    .set_pins   (set_pins),
    .set_pindirs(set_pindirs),
    .pins_we    (pins_we),
    .pindirs_we (pindirs_we),
    .stalled    (stalled)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] jmp(input logic [2:0] c, input logic [4:0] d,
                                      input logic [4:0] a);
    return {3'b000, d, c, a};
  endfunction

  function automatic logic [15:0] set_i(input logic [2:0] dst, input logic [4:0] d,
                                        input logic [4:0] v);
    return {3'b111, d, dst, v};
  endfunction

  // Opcode 101 has no execute path in this core and runs as a NOP.
  function automatic logic [15:0] nop(input logic [4:0] d);
    return {3'b101, d, 8'h42};
  endfunction

  task automatic step(input logic ce);
    clk_en = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; restart = 1'b0; clk_en = 1'b0; exec_valid = 1'b0;
    exec_instr = 16'h0; jmp_pin = 1'b0; osr_empty = 1'b1;
    wrap_bottom = 5'd0; wrap_top = 5'd31;
    for (int i = 0; i < 32; i++) mem[i] = nop(5'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [2:0]  t_cond [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
  logic        t_pin  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        t_osr  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [4:0]  t_pc   [10] = '{5'd7, 5'd7, 5'd1, 5'd7, 5'd1, 5'd1, 5'd7, 5'd1, 5'd7, 5'd1};
  logic [31:0] t_x    [10] = '{0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0};
  logic [31:0] t_y    [10] = '{0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0};

  initial begin
    do_reset();
    check("rst_pc", 32'(pc), 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_stalled", 32'(stalled), 0);
    check("rst_pins", 32'(set_pins), 0);
    check("rst_pins_we", 32'(pins_we), 0);

    // JMP always 3 with delay 2
    do_reset();
    mem[0] = jmp(3'd0, 5'd2, 5'd3);
    enable = 1'b1;
    step(1'b1);
    check("t1_idle_exec_pc", 32'(pc), 0);
    step(1'b1);
    check("t1_jmp_pc", 32'(pc), 3);
    check("t1_stall_a", 32'(stalled), 1);
    step(1'b1);
    check("t1_stall_b", 32'(stalled), 1);
    step(1'b1);
    check("t1_stall_end", 32'(stalled), 0);
    check("t1_pc_hold", 32'(pc), 3);
    step(1'b1);
    check("t1_next_fetch", 32'(pc), 4);

    // reset in the middle of a delay
    do_reset();
    mem[0] = jmp(3'd0, 5'd2, 5'd3);
    enable = 1'b1;
    step(1'b1);
    step(1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid_stalled", 32'(stalled), 0);
    check("rst_mid_pc", 32'(pc), 0);
    reset = 1'b0;

    // every JMP condition from X=Y=0
    for (int i = 0; i < 10; i++) begin
      do_reset();
      mem[0] = jmp(t_cond[i], 5'd0, 5'd7);
      jmp_pin = t_pin[i];
      osr_empty = t_osr[i];
      enable = 1'b1;
      step(1'b1);
      step(1'b1);
      check($sformatf("cond%0d_%0d_pc", t_cond[i], i), 32'(pc), 32'(t_pc[i]));
      check($sformatf("cond%0d_%0d_x", t_cond[i], i), x, t_x[i]);
      check($sformatf("cond%0d_%0d_y", t_cond[i], i), y, t_y[i]);
    end

    // X != Y after X wraps below zero
    do_reset();
    mem[0] = jmp(3'd2, 5'd0, 5'd5);
    mem[1] = jmp(3'd5, 5'd0, 5'd7);
    enable = 1'b1;
    step(1'b1); step(1'b1); step(1'b1);
    check("xney_pc", 32'(pc), 7);

    // SET X 3 then X-- loop at address 1
    do_reset();
    mem[0] = set_i(3'b001, 5'd0, 5'd3);
    mem[1] = jmp(3'd2, 5'd0, 5'd1);
    enable = 1'b1;
    step(1'b1);
    step(1'b1);
    check("loop_set_x", x, SetEn ? 32'd3 : 32'd0);
    check("loop_set_pc", 32'(pc), 1);
`ifdef PIO_SET_INSTR_EN
    step(1'b1); check("loop_x2", x, 2); check("loop_pc_a", 32'(pc), 1);
    step(1'b1); check("loop_x1", x, 1);
    step(1'b1); check("loop_x0", x, 0); check("loop_pc_c", 32'(pc), 1);
`endif
    step(1'b1);
    check("loop_fall_pc", 32'(pc), 2);
    check("loop_fall_x", x, 32'hFFFF_FFFF);

    // wrap 1..4, then JMP at wrap_top overrides the wrap
    do_reset();
    wrap_bottom = 5'd1; wrap_top = 5'd4;
    mem[0] = jmp(3'd0, 5'd0, 5'd1);
    enable = 1'b1;
    step(1'b1);
    step(1'b1); check("wrap_pc1", 32'(pc), 1);
    step(1'b1); check("wrap_pc2", 32'(pc), 2);
    step(1'b1); step(1'b1); check("wrap_pc4", 32'(pc), 4);
    step(1'b1); check("wrap_back", 32'(pc), 1);
    mem[4] = jmp(3'd0, 5'd0, 5'd2);
    step(1'b1); step(1'b1); step(1'b1);
    check("wrap_at_top", 32'(pc), 4);
    step(1'b1); check("wrap_jmp_over", 32'(pc), 2);

    // sparse clk_en with SET PINS / PINDIRS, then disable
    do_reset();
    mem[0] = set_i(3'b000, 5'd0, 5'h15);
    mem[1] = set_i(3'b100, 5'd0, 5'h0A);
    enable = 1'b1;
    step(1'b1);
    step(1'b0); step(1'b0);
    check("ce_frozen_pc", 32'(pc), 0);
    step(1'b1);
    check("ce_pc1", 32'(pc), 1);
    check("ce_set_pins", 32'(set_pins), SetEn ? 32'h15 : 32'h0);
    check("ce_pins_we", 32'(pins_we), 32'(SetEn));
    step(1'b0);
    check("ce_pins_we_drop", 32'(pins_we), 0);
    check("ce_pins_hold", 32'(set_pins), SetEn ? 32'h15 : 32'h0);
    check("ce_pc_hold", 32'(pc), 1);
    step(1'b0);
    step(1'b1);
    check("ce_pc2", 32'(pc), 2);
    check("ce_pindirs", 32'(set_pindirs), SetEn ? 32'h0A : 32'h0);
    check("ce_pindirs_we", 32'(pindirs_we), 32'(SetEn));
    check("ce_pins_we_idle", 32'(pins_we), 0);
    enable = 1'b0;
    step(1'b1); step(1'b1);
    check("dis_pc_hold", 32'(pc), 2);

    // forced JMP cancels delay; restart beats a same-cycle instruction
    do_reset();
    mem[0] = nop(5'd7);
    enable = 1'b1;
    step(1'b1);
    step(1'b1);
    check("fx_stalled", 32'(stalled), 1);
    step(1'b1);
    exec_valid = 1'b1;
    exec_instr = jmp(3'd0, 5'd0, 5'd9);
    step(1'b1);
    exec_valid = 1'b0;
    check("fx_pc", 32'(pc), 9);
    check("fx_unstalled", 32'(stalled), 0);
    mem[9]  = jmp(3'd2, 5'd0, 5'd12);
    mem[10] = jmp(3'd0, 5'd0, 5'd20);
    step(1'b1);
    check("fx_x_dec", x, 32'hFFFF_FFFF);
    restart = 1'b1;
    step(1'b1);
    restart = 1'b0;
    check("rs_pc", 32'(pc), 10);
    check("rs_x", x, 0);
    check("rs_y", y, 0);
    step(1'b1);
    check("rs_resume_pc", 32'(pc), 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
